edge_gen: RTL and testbench

//  Edge/pulse generator: turns single-cycle edge commands into a clean output level with

---
 rtl/edge_gen_pkg.sv | 35 +++
 rtl/edge_gen_if.sv | 27 ++
 rtl/edge_hold_cnt.sv | 26 ++
 rtl/edge_gen.sv | 200 ++++++++++++++++++++
 tb/tb_edge_gen.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/edge_gen_pkg.sv
// Shared types for the edge/pulse generator: FSM states, request codes and
// the request priority encoder.
package edge_gen_pkg;

    localparam int unsigned REQ_VEC_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        PULSE_HI = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        REQ_NONE   = 3'd0,
        REQ_RISE   = 3'd1,
        REQ_FALL   = 3'd2,
        REQ_TOGGLE = 3'd3,
        REQ_PULSE  = 3'd4
    } req_e;

    // vec = {pulse, toggle, rise, fall}; highest bit wins
    function automatic req_e prio_enc(input logic [REQ_VEC_W-1:0] vec);
        if (vec[3]) return REQ_PULSE;
        if (vec[2]) return REQ_TOGGLE;
        if (vec[1]) return REQ_RISE;
        if (vec[0]) return REQ_FALL;
        return REQ_NONE;
    endfunction

    // More than one request strobe in the same cycle
    function automatic logic multi_req(input logic [REQ_VEC_W-1:0] vec);
        return (vec & (vec - REQ_VEC_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/edge_gen_if.sv
// Request/level bundle of the edge generator; master issues requests,
// slave (the generator) drives level, strobes and status.
interface edge_gen_if #(
    parameter int unsigned CNT_W = 8
);
    logic             rise_req;
    logic             fall_req;
    logic             toggle_req;
    logic             pulse_req;
    logic [CNT_W-1:0] pulse_len;
    logic             ready;
    logic             out_level;
    logic             out_rising;
    logic             out_falling;
    logic             out_both;
    logic             drop;

    modport master (
        output rise_req, fall_req, toggle_req, pulse_req, pulse_len,
        input  ready, out_level, out_rising, out_falling, out_both, drop
    );

    modport slave (
        input  rise_req, fall_req, toggle_req, pulse_req, pulse_len,
        output ready, out_level, out_rising, out_falling, out_both, drop
    );
endinterface

// File: rtl/edge_hold_cnt.sv
// Hold/pulse down-counter: load has priority, decrement saturates at zero.
module edge_hold_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             anrst,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero_c
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!anrst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/edge_gen.sv
// Edge/pulse generator: turns edge request strobes into a registered level with
// minimum high/low hold times, a one-deep pending buffer and matching edge strobes.
module edge_gen
    import edge_gen_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned MIN_HIGH   = 4,
    parameter int unsigned MIN_LOW    = 4,
    parameter bit          INIT_LEVEL = 1'b0
) (
    input  logic      clk,
    input  logic      anrst,
    edge_gen_if.slave bus
);
    localparam logic [CNT_W-1:0] HI_LD  = CNT_W'(MIN_HIGH - 1);
    localparam logic [CNT_W-1:0] LO_LD  = CNT_W'(MIN_LOW - 1);
    localparam logic [CNT_W-1:0] HI_MIN = CNT_W'(MIN_HIGH);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             r_both;
    logic             r_drop;
    logic             r_ready;
    logic             r_pend_valid;
    req_e             r_pend_code;
    logic [CNT_W-1:0] r_pend_len;

    logic [REQ_VEC_W-1:0] w_req_vec;
    req_e             w_req;
    logic             w_multi;
    req_e             w_exec_code;
    logic [CNT_W-1:0] w_exec_len;
    logic             w_store;
    logic             w_pend_clr;
    logic             w_rej;
    logic             w_exec_rej;
    logic             w_do_rise;
    logic             w_do_fall;
    logic             w_do_pulse;
    logic             w_pulse_end;
    logic             w_edge_rise;
    logic             w_edge_fall;
    logic [CNT_W-1:0] w_pulse_ld;
    logic             w_cnt_zero;
    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic [CNT_W-1:0] w_cnt_val;
    logic             w_level_nxt;
    logic             w_drop_nxt;
    logic             w_pend_valid_nxt;

    assign w_req_vec = {bus.pulse_req, bus.toggle_req, bus.rise_req, bus.fall_req};
    assign w_req     = prio_enc(w_req_vec);
    assign w_multi   = multi_req(w_req_vec);

    edge_hold_cnt #(.CNT_W(CNT_W)) u_hold_cnt (
        .clk        (clk),
        .anrst      (anrst),
        .i_load     (w_cnt_load),
        .i_dec      (w_cnt_dec),
        .i_load_val (w_cnt_val),
        .o_zero_c   (w_cnt_zero)
    );

    // Choose what executes this cycle and what gets buffered or rejected
    always_comb begin
        w_exec_code = REQ_NONE;
        w_exec_len  = bus.pulse_len;
        w_store     = 1'b0;
        w_pend_clr  = 1'b0;
        w_rej       = w_multi;
        unique case (r_state)
            IDLE: w_exec_code = w_req;
            HOLD: begin
                if (w_cnt_zero && r_pend_valid) begin
                    w_exec_code = r_pend_code;
                    w_exec_len  = r_pend_len;
                    w_pend_clr  = 1'b1;
                    if (w_req != REQ_NONE) w_rej = 1'b1;
                end else if (w_cnt_zero) begin
                    w_exec_code = w_req;
                end else if ((w_req == REQ_PULSE) && r_level) begin
                    w_rej = 1'b1;
                end else if (w_req != REQ_NONE) begin
                    if (r_pend_valid) w_rej = 1'b1;
                    else              w_store = 1'b1;
                end
            end
            PULSE_HI: begin
                if (w_req == REQ_PULSE) begin
                    w_rej = 1'b1;
                end else if (w_req != REQ_NONE) begin
                    if (r_pend_valid) w_rej = 1'b1;
                    else              w_store = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Redundant rise/fall are consumed silently; a pulse needs a low level
    always_comb begin
        w_do_rise  = 1'b0;
        w_do_fall  = 1'b0;
        w_do_pulse = 1'b0;
        w_exec_rej = 1'b0;
        unique case (w_exec_code)
            REQ_RISE:   w_do_rise = !r_level;
            REQ_FALL:   w_do_fall = r_level;
            REQ_TOGGLE: begin
                w_do_rise = !r_level;
                w_do_fall = r_level;
            end
            REQ_PULSE: begin
                w_do_pulse = !r_level;
                w_exec_rej = r_level;
            end
            default: ;
        endcase
    end

    // Pulse high time is max(len, MIN_HIGH); len 0 falls into the MIN_HIGH case
    always_comb begin
        w_pulse_ld = HI_LD;
        if (w_exec_len > HI_MIN) w_pulse_ld = w_exec_len - CNT_W'(1);
    end

    assign w_pulse_end = (r_state == PULSE_HI) && w_cnt_zero;
    assign w_edge_rise = w_do_rise || w_do_pulse;
    assign w_edge_fall = w_do_fall || w_pulse_end;

    always_ff @(posedge clk) begin
        if (!anrst) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_do_pulse)                         w_state_nxt = PULSE_HI;
        else if (w_edge_rise || w_edge_fall)    w_state_nxt = HOLD;
        else if ((r_state == HOLD) && w_cnt_zero) w_state_nxt = IDLE;
    end

    always_comb begin
        w_level_nxt = r_level;
        if (w_edge_rise)      w_level_nxt = 1'b1;
        else if (w_edge_fall) w_level_nxt = 1'b0;
        w_drop_nxt       = w_rej || w_exec_rej;
        w_pend_valid_nxt = r_pend_valid;
        if (w_store)         w_pend_valid_nxt = 1'b1;
        else if (w_pend_clr) w_pend_valid_nxt = 1'b0;
        w_cnt_load = w_edge_rise || w_edge_fall;
        w_cnt_val  = w_do_pulse ? w_pulse_ld : (w_edge_rise ? HI_LD : LO_LD);
        w_cnt_dec  = (r_state != IDLE);
    end

    // Strobes come from the same edge decision that moves the level
    always_ff @(posedge clk) begin
        if (!anrst) begin
            r_level <= INIT_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_both  <= 1'b0;
            r_drop  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_level <= w_level_nxt;
            r_rise  <= w_edge_rise;
            r_fall  <= w_edge_fall;
            r_both  <= w_edge_rise || w_edge_fall;
            r_drop  <= w_drop_nxt;
            r_ready <= !w_pend_valid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!anrst) begin
            r_pend_valid <= 1'b0;
            r_pend_code  <= REQ_NONE;
            r_pend_len   <= '0;
        end else begin
            r_pend_valid <= w_pend_valid_nxt;
            if (w_store) begin
                r_pend_code <= w_req;
                r_pend_len  <= bus.pulse_len;
            end
        end
    end

    assign bus.out_level   = r_level;
    assign bus.out_rising  = r_rise;
    assign bus.out_falling = r_fall;
    assign bus.out_both    = r_both;
    assign bus.drop        = r_drop;
    assign bus.ready       = r_ready;

endmodule

// File: tb/tb_edge_gen.sv
// Directed bench for edge_gen: stimulus pushes hand-computed per-cycle output
// vectors into a scoreboard, a negedge monitor pops and compares them.
module tb_edge_gen;
    localparam int unsigned CNT_W = 8;

    logic clk;
    logic anrst;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // v = {level, rising, falling, both, drop, ready}
    typedef struct {
        int         c;
        logic [5:0] v;
        string      name;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [5:0] act;

    edge_gen_if #(.CNT_W(CNT_W)) bus ();

    edge_gen #(
        .CNT_W      (CNT_W),
        .MIN_HIGH   (4),
        .MIN_LOW    (3),
        .INIT_LEVEL (1'b0)
    ) dut (
        .clk   (clk),
        .anrst (anrst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input logic lvl, input logic rise,
                             input logic fall, input logic drp, input logic rdy,
                             input string name);
        exp_t e;
        e.c    = c;
        e.v    = {lvl, rise, fall, rise | fall, drp, rdy};
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic req(input logic r, input logic f, input logic tg, input logic p,
                       input logic [CNT_W-1:0] len);
        bus.rise_req   = r;
        bus.fall_req   = f;
        bus.toggle_req = tg;
        bus.pulse_req  = p;
        bus.pulse_len  = len;
        @(negedge clk);
        bus.rise_req   = 1'b0;
        bus.fall_req   = 1'b0;
        bus.toggle_req = 1'b0;
        bus.pulse_req  = 1'b0;
        bus.pulse_len  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].c <= cyc) begin
            mon_e = sb.pop_front();
            act   = {bus.out_level, bus.out_rising, bus.out_falling,
                     bus.out_both, bus.drop, bus.ready};
            checks++;
            if (mon_e.c != cyc || act !== mon_e.v) begin
                errors++;
                $display("FAIL %s cyc=%0d (due %0d) lvl/rise/fall/both/drop/ready got=%b exp=%b",
                         mon_e.name, cyc, mon_e.c, act, mon_e.v);
            end
        end
    end

    initial begin
        int t;
        bus.rise_req   = 1'b0;
        bus.fall_req   = 1'b0;
        bus.toggle_req = 1'b0;
        bus.pulse_req  = 1'b0;
        bus.pulse_len  = '0;
        anrst          = 1'b0;

        // reset state
        idle(2);
        t = cyc;
        expect_at(t + 1, 0, 0, 0, 0, 1, "reset");
        @(negedge clk);
        anrst = 1'b1;
        idle(2);

        // single rise, then fall
        t = cyc;
        expect_at(t + 1, 1, 1, 0, 0, 1, "t1_rise");
        expect_at(t + 2, 1, 0, 0, 0, 1, "t1_strobe_once");
        req(1, 0, 0, 0, 0);
        idle(4);
        t = cyc;
        expect_at(t + 1, 0, 0, 1, 0, 1, "t1_fall");
        req(0, 1, 0, 0, 0);
        idle(4);

        // fall arrives during high hold -> pending, fires after 4 high cycles
        t = cyc;
        expect_at(t + 1, 1, 1, 0, 0, 1, "t2_rise");
        expect_at(t + 2, 1, 0, 0, 0, 0, "t2_ready_low_first");
        expect_at(t + 4, 1, 0, 0, 0, 0, "t2_ready_low_last");
        expect_at(t + 5, 0, 0, 1, 0, 1, "t2_fall_after_hold");
        expect_at(t + 6, 0, 0, 0, 0, 1, "t2_settled");
        req(1, 0, 0, 0, 0);
        req(0, 1, 0, 0, 0);
        idle(6);

        // pending full: toggle dropped
        t = cyc;
        expect_at(t + 1, 1, 1, 0, 0, 1, "t3_rise");
        expect_at(t + 3, 1, 0, 0, 1, 0, "t3_drop");
        expect_at(t + 4, 1, 0, 0, 0, 0, "t3_drop_once");
        expect_at(t + 5, 0, 0, 1, 0, 1, "t3_fall_only");
        expect_at(t + 6, 0, 0, 0, 0, 1, "t3_no_extra");
        expect_at(t + 8, 0, 0, 0, 0, 1, "t3_toggle_gone");
        req(1, 0, 0, 0, 0);
        req(0, 1, 0, 0, 0);
        req(0, 0, 1, 0, 0);
        idle(5);

        // pulse len 2 clamped to MIN_HIGH
        t = cyc;
        expect_at(t + 1, 1, 1, 0, 0, 1, "t4a_rise");
        expect_at(t + 4, 1, 0, 0, 0, 1, "t4a_high4");
        expect_at(t + 5, 0, 0, 1, 0, 1, "t4a_fall");
        req(0, 0, 0, 1, 8'd2);
        idle(7);

        // pulse len 0 treated as 1, then clamped
        t = cyc;
        expect_at(t + 1, 1, 1, 0, 0, 1, "t4z_rise");
        expect_at(t + 4, 1, 0, 0, 0, 1, "t4z_high4");
        expect_at(t + 5, 0, 0, 1, 0, 1, "t4z_fall");
        req(0, 0, 0, 1, 8'd0);
        idle(7);

        // pulse len 6 with a rise pended during it; rise waits out MIN_LOW
        t = cyc;
        expect_at(t + 1,  1, 1, 0, 0, 1, "t4b_rise");
        expect_at(t + 3,  1, 0, 0, 0, 0, "t4b_pend");
        expect_at(t + 6,  1, 0, 0, 0, 0, "t4b_high6");
        expect_at(t + 7,  0, 0, 1, 0, 0, "t4b_fall");
        expect_at(t + 9,  0, 0, 0, 0, 0, "t4b_low3");
        expect_at(t + 10, 1, 1, 0, 0, 1, "t4b_pend_rise");
        expect_at(t + 13, 1, 0, 0, 0, 0, "t4b_hold_high");
        expect_at(t + 14, 0, 0, 1, 0, 1, "t4b_pend_fall");
        req(0, 0, 0, 1, 8'd6);
        idle(1);
        req(1, 0, 0, 0, 0);
        idle(8);
        req(0, 1, 0, 0, 0);
        idle(6);

        // rise+fall together: rise wins, loser dropped
        t = cyc;
        expect_at(t + 1, 1, 1, 0, 1, 1, "t5_rise_drop");
        expect_at(t + 2, 1, 0, 0, 0, 1, "t5_drop_once");
        req(1, 1, 0, 0, 0);
        idle(4);
        t = cyc;
        expect_at(t + 1, 0, 0, 1, 0, 1, "t5_fall");
        req(0, 1, 0, 0, 0);
        idle(4);

        // redundant fall while low
        t = cyc;
        expect_at(t + 1, 0, 0, 0, 0, 1, "t5_fall_redundant");
        expect_at(t + 2, 0, 0, 0, 0, 1, "t5_fall_redundant2");
        req(0, 1, 0, 0, 0);
        idle(2);

        // pulse while high is dropped
        t = cyc;
        expect_at(t + 1, 1, 1, 0, 0, 1, "ph_rise");
        expect_at(t + 6, 1, 0, 0, 1, 1, "ph_pulse_drop");
        expect_at(t + 7, 0, 0, 1, 0, 1, "ph_fall");
        req(1, 0, 0, 0, 0);
        idle(4);
        req(0, 0, 0, 1, 8'd5);
        req(0, 1, 0, 0, 0);
        idle(4);

        // toggle both ways
        t = cyc;
        expect_at(t + 1, 1, 1, 0, 0, 1, "tg_rise");
        expect_at(t + 6, 0, 0, 1, 0, 1, "tg_fall");
        req(0, 0, 1, 0, 0);
        idle(4);
        req(0, 0, 1, 0, 0);
        idle(4);

        // reset in cycle 3 of a 6-cycle pulse, with a rise pending
        t = cyc;
        expect_at(t + 1, 1, 1, 0, 0, 1, "t6_rise");
        expect_at(t + 3, 1, 0, 0, 0, 0, "t6_mid_pulse");
        expect_at(t + 4, 0, 0, 0, 0, 1, "t6_reset");
        expect_at(t + 5, 0, 0, 0, 0, 1, "t6_pend_cleared");
        expect_at(t + 6, 1, 1, 0, 0, 1, "t6_after_reset");
        req(0, 0, 0, 1, 8'd6);
        idle(1);
        req(1, 0, 0, 0, 0);
        anrst = 1'b0;
        @(negedge clk);
        anrst = 1'b1;
        idle(1);
        req(1, 0, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
